// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
//   Buffers up to DEPTH operand pairs, then streams them into an external
//   8x8->16 accumulating MAC. After the last pair it sends two flush beats
//   and captures the MAC dot product on a single capture beat.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   load_valid/load_ready   operand pair handshake (load_a, load_b)
//   start                   launch a run over every buffered pair
//   busy, done              run in progress / one-cycle result strobe
//   result, result_err      captured sum; err set if MAC valid was low
//   mac_enable, mac_a/b     registered drive to the MAC
//   mac_valid, mac_c        MAC outputs, sampled on the capture beat
//
// States
//   IDLE    | accepting loads, MAC inputs held at zero
//   RUN     | one buffered pair per cycle into the MAC
//   FLUSH   | two enabled zero beats so the last product reaches mac_c
//   CAPTURE | MAC disabled; sample mac_c / mac_valid into result
module mac_operand_sequencer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [7:0]       load_a,
    input  logic [7:0]       load_b,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output logic             result_err,
    output logic             mac_enable,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    input  logic             mac_valid,
    input  logic [15:0]      mac_c
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_CAPTURE
    } state_t;

    state_t state, state_n;

    logic [7:0]       mem_a [DEPTH];
    logic [7:0]       mem_b [DEPTH];

    logic [CNT_W-1:0] cnt, cnt_n;
    // tmr counts down the beats left in RUN or FLUSH; idx addresses the
    // pair currently on mac_a/mac_b.
    logic [CNT_W-1:0] tmr, tmr_n;
    logic [AW-1:0]    idx, idx_n;
    logic [AW-1:0]    idx_inc;

    logic             en_n;
    logic [7:0]       a_n, b_n;
    logic             busy_n, done_n, err_n;
    logic [15:0]      result_n;

    logic             load_fire;
    logic             start_ok;

    // start has priority over a load offered in the same cycle
    assign load_ready = (state == S_IDLE) && !start && (cnt < DEPTH_C);
    assign load_fire  = load_valid && load_ready;
    assign start_ok   = (state == S_IDLE) && start && (cnt != '0);
    assign idx_inc    = idx + AW'(1);

    // Buffer contents survive runs and reset; only cnt decides what is used.
    always_ff @(posedge clk) begin
        if (!reset && load_fire) begin
            mem_a[cnt[AW-1:0]] <= load_a;
            mem_b[cnt[AW-1:0]] <= load_b;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        tmr_n    = tmr;
        idx_n    = idx;
        en_n     = 1'b0;
        a_n      = 8'h00;
        b_n      = 8'h00;
        busy_n   = busy;
        done_n   = 1'b0;
        err_n    = result_err;
        result_n = result;

        unique case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                    tmr_n   = cnt - CNT_W'(1);
                    idx_n   = '0;
                    en_n    = 1'b1;
                    a_n     = mem_a[0];
                    b_n     = mem_b[0];
                    busy_n  = 1'b1;
                end else if (load_fire) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                en_n = 1'b1;
                if (tmr == '0) begin
                    // zeros keep the MAC input flops from re-adding the
                    // last pair and leave them clear for the next run
                    state_n = S_FLUSH;
                    tmr_n   = CNT_W'(1);
                end else begin
                    tmr_n = tmr - CNT_W'(1);
                    idx_n = idx_inc;
                    a_n   = mem_a[idx_inc];
                    b_n   = mem_b[idx_inc];
                end
            end
            S_FLUSH: begin
                if (tmr == '0) begin
                    state_n = S_CAPTURE;
                end else begin
                    en_n  = 1'b1;
                    tmr_n = tmr - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                state_n  = S_IDLE;
                result_n = mac_c;
                err_n    = !mac_valid;
                done_n   = 1'b1;
                busy_n   = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            tmr        <= '0;
            idx        <= '0;
            mac_enable <= 1'b0;
            mac_a      <= 8'h00;
            mac_b      <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 16'h0000;
            result_err <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            tmr        <= tmr_n;
            idx        <= idx_n;
            mac_enable <= en_n;
            mac_a      <= a_n;
            mac_b      <= b_n;
            busy       <= busy_n;
            done       <= done_n;
            result     <= result_n;
            result_err <= err_n;
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
module tb_mac_operand_sequencer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_a;
    logic [7:0]  load_b;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        result_err;
    logic        mac_enable;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic        mac_valid;
    logic [15:0] mac_c;

    always #5 clk = ~clk;

    mac_operand_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_a     (load_a),
        .load_b     (load_b),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_err (result_err),
        .mac_enable (mac_enable),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_valid  (mac_valid),
        .mac_c      (mac_c)
    );

    // Stand-in for mac_unit: input flops, accumulate one cycle later,
    // registered output one cycle after that; clears while disabled.
    logic [7:0]  ma_r, mb_r;
    logic [15:0] acc, mc_r;
    logic        mv_r;
    bit          force_inv = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            ma_r <= 8'h00; mb_r <= 8'h00; acc <= 16'h0; mc_r <= 16'h0; mv_r <= 1'b0;
        end else if (mac_enable) begin
            ma_r <= mac_a;
            mb_r <= mac_b;
            acc  <= acc + {8'h00, ma_r} * {8'h00, mb_r};
            mc_r <= acc;
            mv_r <= 1'b1;
        end else begin
            acc  <= 16'h0;
            mv_r <= 1'b0;
        end
    end
    assign mac_c     = mc_r;
    assign mac_valid = mv_r & ~force_inv;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic        err;
        int          t;
        int          n;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         busy_until = 0;
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done strobe.
    int en_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                en_cnt = 0;
            end else begin
                if (mac_enable) en_cnt++;
                if (done) begin
                    if (sbq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: result 0x%0h with no run pending", result);
                    end else begin
                        e = sbq.pop_front();
                        chk("result", int'(result), int'(e.res));
                        chk("result_err", int'(result_err), int'(e.err));
                        chk("done_latency", cyc, e.t + e.n + 3);
                        chk("busy_at_done", int'(busy), 0);
                        chk("enable_cycles", en_cnt, e.n + 2);
                    end
                    en_cnt = 0;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_result"}, int'(result), 0);
        chk({tag, "_err"}, int'(result_err), 0);
        chk({tag, "_mac_enable"}, int'(mac_enable), 0);
        chk({tag, "_mac_a"}, int'(mac_a), 0);
        chk({tag, "_mac_b"}, int'(mac_b), 0);
        chk({tag, "_load_ready"}, int'(load_ready), 1);
    endtask

    task automatic load_pair(input logic [7:0] a, input logic [7:0] b);
        bit exp_r;
        @(negedge clk);
        load_valid = 1'b1; load_a = a; load_b = b; start = 1'b0;
        #1;
        exp_r = (cyc >= busy_until) && (qa.size() < DEPTH);
        chk("load_ready", int'(load_ready), int'(exp_r));
        if (exp_r) begin
            qa.push_back(a);
            qb.push_back(b);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        load_valid = 1'b0; start = 1'b0;
    endtask

    task automatic do_start(input bit with_load);
        bit   idle_now, taken;
        int   sum;
        exp_t e;
        @(negedge clk);
        start = 1'b1; load_valid = with_load;
        load_a = 8'($urandom); load_b = 8'($urandom);
        #1;
        chk("load_ready_during_start", int'(load_ready), 0);
        idle_now = (cyc >= busy_until);
        taken    = idle_now && (qa.size() > 0);
        if (taken) begin
            sum = 0;
            foreach (qa[i]) sum += int'(qa[i]) * int'(qb[i]);
            e.res = 16'(sum % 65536);
            e.err = force_inv;
            e.t   = cyc + 1;
            e.n   = qa.size();
            sbq.push_back(e);
            busy_until = e.t + e.n + 3;
            qa.delete();
            qb.delete();
        end
        @(negedge clk);
        start = 1'b0; load_valid = 1'b0;
        #1;
        chk("busy_after_start", int'(busy), int'(taken || !idle_now));
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic load_vec(input int n, input int base_a, input int base_b, input int step);
        for (int i = 0; i < n; i++) load_pair(8'(base_a + i * step), 8'(base_b + i * step));
    endtask

    initial begin
        reset = 1'b1; load_valid = 1'b0; load_a = 8'h0; load_b = 8'h0; start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        // [1,2,3].[4,5,6]; the extra load offered with start must be refused
        load_vec(3, 1, 4, 1);
        do_start(1'b1);
        wait_done();

        load_pair(8'h10, 8'h10);
        do_start(1'b1);
        wait_done();

        // fill to DEPTH, ninth pair refused, wrapping sum
        for (int i = 0; i < DEPTH + 1; i++) load_pair(8'hFF, 8'hFF);
        do_start(1'b0);
        wait_done();

        // back-to-back: load in the done cycle, no residue from previous run
        load_vec(3, 1, 4, 1);
        do_start(1'b0);
        wait_done();
        load_pair(8'd7, 8'd7);
        do_start(1'b0);
        wait_done();
        do_start(1'b0);            // empty buffer, in the done cycle: ignored
        repeat (4) idle_cycle();
        chk("busy_after_empty_start", int'(busy), 0);

        // reset while pair 1 is on the MAC inputs
        load_vec(3, 1, 4, 1);
        do_start(1'b0);
        @(negedge clk);
        reset = 1'b1;
        sbq.delete(); qa.delete(); qb.delete();
        busy_until = 0;
        @(negedge clk);
        #1;
        check_reset_outputs("mid_run");
        @(negedge clk);
        reset = 1'b0;
        load_pair(8'd2, 8'd2);
        load_pair(8'd3, 8'd3);
        do_start(1'b0);
        wait_done();

        // MAC valid low at capture
        load_pair(8'($urandom), 8'($urandom));
        load_pair(8'($urandom), 8'($urandom));
        force_inv = 1'b1;
        do_start(1'b0);
        wait_done();
        force_inv = 1'b0;

        // randomized runs with idle gaps and occasional overfill attempts
        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(1, DEPTH + 1);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                load_pair(8'($urandom), 8'($urandom));
            end
            if ($urandom_range(0, 1) == 1) idle_cycle();
            do_start(1'($urandom_range(0, 1)));
            wait_done();
        end

        repeat (6) idle_cycle();
        chk("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_operand_sequencer.md
# mac_operand_sequencer

Upstream feeder for the 8x8->16 `mac_unit` accumulator. It buffers two operand vectors through a valid/ready load port. On `start`, it streams the element pairs into the MAC with the correct enable and flush timing, then captures the 16-bit dot product and pulses `done`. It also owns the MAC result: it samples `c`/`valid` at the single cycle where the full sum is present.

## Interface
Parameters:
- DEPTH, 8: max vector length (element pairs buffered); legal 1..16.
- CNT_W, 5: width of fill/beat counters; must hold DEPTH.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high. The top ties the MAC's `reset_n` to `~reset`.
- load_valid  in  1  element pair offered.
- load_ready  out  1  pair accepted on an edge where `load_valid && load_ready`.
- load_a  in  8  vector A element.
- load_b  in  8  vector B element.
- start  in  1  launch a dot product over all buffered pairs.
- busy  out  1  high from the `start`-accept edge until `done` rises.
- done  out  1  one-cycle pulse: `result` is valid.
- result  out  16  captured dot product, held until the next capture or reset.
- result_err  out  1  set with `done` if the MAC `valid` was low at capture.
- mac_enable  out  1  to MAC `enable`; registered.
- mac_a  out  8  to MAC `a`; registered.
- mac_b  out  8  to MAC `b`; registered.
- mac_valid  in  1  from MAC `valid`.
- mac_c  in  16  from MAC `c`.

## Operation
- Buffer: two DEPTH x 8 register arrays plus a fill count `cnt`. An accepted load writes index `cnt`, then `cnt++`.
- `load_ready = (state==IDLE) && !start && (cnt < DEPTH)`. `start` has priority: a load offered in the same cycle as `start` is not taken.
- `start` is ignored unless state==IDLE and `cnt >= 1`. Run length N = `cnt` at the accept edge. `cnt` clears when the run is accepted.
- States:
  - IDLE: accepting loads; `mac_enable=0`, `mac_a=mac_b=0`.
  - RUN: N beats; beat i drives `mac_a=A[i]`, `mac_b=B[i]`, `mac_enable=1`.
  - FLUSH: 2 beats with `mac_enable=1` and `mac_a=mac_b=0`.
  - CAPTURE: 1 beat with `mac_enable=0`; sample `mac_c` and `mac_valid`.
  - Transitions: IDLE->RUN on accepted start; RUN->FLUSH after beat N-1; FLUSH->CAPTURE after 2 beats; CAPTURE->IDLE.
- Why FLUSH exists:
  - The MAC registers its inputs, accumulates one cycle later, and registers its output one more cycle later. Two extra enabled edges are therefore needed.
  - Zero operands in FLUSH prevent the last pair from being re-added while the MAC input flops hold it.
  - The zeros also leave the MAC input flops at 0, so the next run's first accumulate adds 0.
- Arithmetic: `result = sum(A[i]*B[i]) mod 2^16`, identical to the MAC's wrapping 16-bit accumulator. No saturation.
- Buffer contents are not cleared after a run; only `cnt` resets. A new run uses only the newly loaded pairs.
- Reset, at any time including mid-RUN or mid-FLUSH:
  - state=IDLE, `cnt=0`;
  - `mac_enable=0`, `mac_a=mac_b=0`;
  - `busy=0`, `done=0`, `result=0`, `result_err=0`.

## Timing
- Reset values: `load_ready=1` (deasserted while `start` is high), `busy=0`, `done=0`, `result=0x0000`, `result_err=0`, `mac_enable=0`, `mac_a=0`, `mac_b=0`.
- Edge numbering: `start` accepted at edge T. `busy` rises after T.
- Pair i is driven after edge T+i, so the MAC captures it at edge T+1+i, for i = 0..N-1.
- Zeros are driven after edges T+N and T+N+1. `mac_enable` is low after edge T+N+2.
- MAC `c` holds the full sum in the cycle after edge T+N+2.
- At edge T+N+3:
  - `result <= mac_c`;
  - `result_err <= !mac_valid`;
  - `done` goes high for exactly one cycle;
  - `busy` goes low.
- Latency from start accept to `done` high: N+3 cycles. The next `start` can be accepted in the `done` cycle if `cnt >= 1`.
- Loads are accepted from the `done` cycle onward. No loads are accepted while `busy` is high.

## Test plan
- Load 3 pairs A=[1,2,3], B=[4,5,6], start at T -> `done` after edge T+6, `result=0x0020`, `result_err=0`. `mac_enable` is high for exactly 5 cycles.
- Load 1 pair (0x10,0x10), start -> `done` after edge T+4, `result=0x0100`.
- Load 8 pairs of (0xFF,0xFF) -> `load_ready` low once `cnt=8` and a 9th pair is refused; run gives `result=0xF008` (520200 mod 65536).
- Run [1,2,3]·[4,5,6], then immediately load [7]·[7] and start in the `done` cycle -> second `result=0x0031` (no residue from run 1). Start with `cnt=0` -> ignored; `busy` stays 0.
- Assert `reset` during RUN beat 1 -> next cycle all outputs at reset values. A fresh 2-pair run [2,3]·[2,3] then gives `0x000D`.
- Force `mac_valid=0` at the capture cycle -> `done` pulses with `result_err=1`.
